// File: rtl/rs_syn_arb_pkg.sv
// Shared types and constants for the RS syndrome codeword arbiter.
// No logic: compile-time only.
// No flow control: package contents only.
package rs_syn_arb_pkg;

    typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} arb_state_t;

    // Defaults shared with the syndrome wrapper so both sides agree on geometry.
    localparam int RS_N_DEFAULT   = 255;
    localparam int RS_BPS_DEFAULT = 8;

    function automatic int clog2_w(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rs_syn_cw_arbiter_rr_pick.sv
// Round-robin picker: first set candidate at or after ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// No flow control: pure function of its inputs.
module rs_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] cand,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            found
);

    logic [NREQ-1:0] rot;

    // Rotating the doubled vector puts the pointer's source at bit 0; lowest set bit wins.
    always_comb begin
        rot   = NREQ'({cand, cand} >> ptr);
        idx   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/rs_syn_cw_arbiter.sv
// Packet-atomic round-robin arbiter feeding the serial RS syndrome block; optional length check under RS_SYN_ARB_LEN_CHECK_EN.
// Latency: zero-cycle pass-through during a codeword, one idle arbitration cycle between codewords.
// Backpressure: cw_out_ready stalls only the granted source; the grant holds until its eop beat.
module rs_syn_cw_arbiter
    import rs_syn_arb_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int BITSPERSYMBOL = RS_BPS_DEFAULT,
    parameter int N             = RS_N_DEFAULT,
    parameter int CHWIDTH       = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ-1:0]                 req_sop,
    input  logic [NREQ-1:0]                 req_eop,
    input  logic [NREQ-1:0]                 req_erasure,
    input  logic [NREQ*BITSPERSYMBOL-1:0]   req_data,
    output logic [NREQ-1:0]                 req_ready,
    output logic                            cw_out_valid,
    output logic                            cw_out_sop,
    output logic                            cw_out_eop,
    output logic                            cw_out_erasure,
    output logic [BITSPERSYMBOL-1:0]        cw_out_data,
    output logic [CHWIDTH-1:0]              cw_out_channel,
    input  logic                            cw_out_ready,
    output logic                            busy,
    output logic [CHWIDTH-1:0]              grant_id,
    output logic                            orphan_err,
    output logic                            len_err
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_XFER = XFER;

    if (NREQ < 2 || NREQ > 8 || CHWIDTH < clog2_w(NREQ) || N < 1) begin : g_cfg_err
        $error("rs_syn_cw_arbiter: illegal NREQ/CHWIDTH/N combination");
    end

    logic [0:0]         state;
    logic [CHWIDTH-1:0] rr_ptr;
    logic [NREQ-1:0]    cand;
    logic [NREQ-1:0]    gsel;
    logic [CHWIDTH-1:0] pick_idx;
    logic               pick_found;
    logic               beat;

    assign cand = req_valid & req_sop;

    rs_rr_pick #(
        .NREQ (NREQ),
        .IW   (CHWIDTH)
    ) u_pick (
        .cand  (cand),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            gsel[i] = (grant_id == CHWIDTH'(i));
        end
    end

    // Outputs are forced quiet while rst is held so the reset is visible without a clock.
    always_comb begin
        req_ready      = '0;
        cw_out_valid   = 1'b0;
        cw_out_sop     = 1'b0;
        cw_out_eop     = 1'b0;
        cw_out_erasure = 1'b0;
        cw_out_data    = '0;
        if (!rst) begin
            if (state == ST_XFER) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gsel[i]) begin
                        cw_out_valid   = req_valid[i];
                        cw_out_sop     = req_sop[i];
                        cw_out_eop     = req_eop[i];
                        cw_out_erasure = req_erasure[i];
                        cw_out_data    = req_data[i*BITSPERSYMBOL +: BITSPERSYMBOL];
                        req_ready[i]   = cw_out_ready;
                    end
                end
            end else begin
                req_ready = req_valid & ~req_sop;
            end
        end
    end

    assign cw_out_channel = grant_id;
    assign busy           = (state == ST_XFER);
    assign beat           = cw_out_valid & cw_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            orphan_err <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (|(req_valid & ~req_sop)) begin
                orphan_err <= 1'b1;
            end
            if (pick_found) begin
                grant_id <= pick_idx;
                state    <= ST_XFER;
            end
        end else if (beat && cw_out_eop) begin
            state  <= ST_IDLE;
            rr_ptr <= (grant_id == CHWIDTH'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

`ifdef RS_SYN_ARB_LEN_CHECK_EN
    localparam int CW = clog2_w(N + 1);

    logic [CW-1:0] sym_cnt;
    logic          len_err_q;

    // Counter saturates at N so a runaway codeword flags once, then again at its eop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_cnt   <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            if (state == ST_IDLE) begin
                if (pick_found) begin
                    sym_cnt <= '0;
                end
            end else if (beat) begin
                if (cw_out_eop) begin
                    len_err_q <= ((sym_cnt + 1'b1) != CW'(N));
                end else if (sym_cnt != CW'(N)) begin
                    sym_cnt <= sym_cnt + 1'b1;
                    if ((sym_cnt + 1'b1) == CW'(N)) begin
                        len_err_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_rs_syn_cw_arbiter.sv
// Directed bench for rs_syn_cw_arbiter: sources driven from per-source codeword descriptors.
module tb_rs_syn_cw_arbiter;

    localparam int NREQ = 2;
    localparam int BPS  = 8;
    localparam int N    = 255;
    localparam int CHW  = 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_sop;
    logic [NREQ-1:0]       req_eop;
    logic [NREQ-1:0]       req_erasure;
    logic [NREQ*BPS-1:0]   req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  cw_out_valid;
    logic                  cw_out_sop;
    logic                  cw_out_eop;
    logic                  cw_out_erasure;
    logic [BPS-1:0]        cw_out_data;
    logic [CHW-1:0]        cw_out_channel;
    logic                  cw_out_ready;
    logic                  busy;
    logic [CHW-1:0]        grant_id;
    logic                  orphan_err;
    logic                  len_err;

    always #5 clk = ~clk;

    rs_syn_cw_arbiter #(
        .NREQ          (NREQ),
        .BITSPERSYMBOL (BPS),
        .N             (N),
        .CHWIDTH       (CHW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_sop        (req_sop),
        .req_eop        (req_eop),
        .req_erasure    (req_erasure),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .cw_out_valid   (cw_out_valid),
        .cw_out_sop     (cw_out_sop),
        .cw_out_eop     (cw_out_eop),
        .cw_out_erasure (cw_out_erasure),
        .cw_out_data    (cw_out_data),
        .cw_out_channel (cw_out_channel),
        .cw_out_ready   (cw_out_ready),
        .busy           (busy),
        .grant_id       (grant_id),
        .orphan_err     (orphan_err),
        .len_err        (len_err)
    );

    int          s_cnt  [NREQ];
    int          s_len  [NREQ];
    int          s_reps [NREQ];
    logic [7:0]  s_base [NREQ];
    logic        s_orph [NREQ];
    logic [NREQ-1:0] acc;
    logic        tog;
    logic        chk_rdy;
    int          cyc, busy_cnt, len_cnt, len_cyc, eop_cyc;
    logic [7:0]  q_dat [$];
    logic        q_ch  [$];
    logic        q_sop [$];
    logic        q_eop [$];
    logic        q_era [$];
    int          q_cyc [$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task drive();
        logic [NREQ-1:0]     v, s, e, er;
        logic [NREQ*BPS-1:0] d;
        v = '0; s = '0; e = '0; er = '0; d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (s_orph[i]) begin
                v[i] = 1'b1;
                d[i*BPS +: BPS] = 8'hAA;
            end else if (s_reps[i] > 0) begin
                v[i]  = 1'b1;
                s[i]  = (s_cnt[i] == 0);
                e[i]  = (s_cnt[i] == s_len[i] - 1);
                er[i] = (s_cnt[i] % 4 == 3);
                d[i*BPS +: BPS] = s_base[i] + 8'(s_cnt[i]);
            end
        end
        req_valid = v; req_sop = s; req_eop = e; req_erasure = er; req_data = d;
    endtask

    task advance();
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                if (s_orph[i]) begin
                    s_orph[i] = 1'b0;
                end else if (s_cnt[i] == s_len[i] - 1) begin
                    s_cnt[i]  = 0;
                    s_reps[i] = s_reps[i] - 1;
                end else begin
                    s_cnt[i] = s_cnt[i] + 1;
                end
            end
        end
        if (tog) cw_out_ready = ~cw_out_ready;
    endtask

    task sample();
        cyc++;
        if (cw_out_valid && cw_out_ready) begin
            q_dat.push_back(cw_out_data);
            q_ch.push_back(cw_out_channel);
            q_sop.push_back(cw_out_sop);
            q_eop.push_back(cw_out_eop);
            q_era.push_back(cw_out_erasure);
            q_cyc.push_back(cyc);
            if (cw_out_eop) eop_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (len_err) begin
            len_cnt++;
            len_cyc = cyc;
        end
        if (chk_rdy && busy) begin
            chk("bp_rdy_mirror", req_ready[grant_id], cw_out_ready);
            chk("bp_rdy_other", req_ready[grant_id ^ 1'b1], 0);
        end
        acc = req_valid & req_ready;
    endtask

    task tick();
        @(posedge clk);
        #1;
        advance();
        drive();
        #1;
        sample();
    endtask

    task clear_mon();
        q_dat.delete(); q_ch.delete(); q_sop.delete();
        q_eop.delete(); q_era.delete(); q_cyc.delete();
        cyc = 0; busy_cnt = 0; len_cnt = 0; len_cyc = -1; eop_cyc = -1;
    endtask

    task reset_dut();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            s_cnt[i] = 0; s_len[i] = 1; s_reps[i] = 0; s_base[i] = 8'h00; s_orph[i] = 1'b0;
        end
        tog = 1'b0; chk_rdy = 1'b0; cw_out_ready = 1'b1; acc = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_idle(input string tag, input int max_cyc);
        logic done;
        done = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            tick();
            done = (s_reps[0] == 0) && (s_reps[1] == 0) && !s_orph[0] && !s_orph[1] && !busy;
            if (done) break;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_len;
        logic [7:0] exp_d;
        logic exp_c;
        int j;
        clear_mon();
        reset_dut();

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_valid", cw_out_valid, 0);
        chk("rst_orph", orphan_err, 0);

        // 1: single source, 255 symbols 0x01..0xFF
        clear_mon();
        s_len[0] = 255; s_base[0] = 8'h01; s_reps[0] = 1;
        tick();
        chk("t1_idle_valid", cw_out_valid, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_ready", req_ready, 0);
        run_idle("t1", 300);
        chk("t1_beats", q_dat.size(), 255);
        for (int k = 0; k < q_dat.size(); k++) begin
            chk("t1_data", q_dat[k], k + 1);
            chk("t1_chan", q_ch[k], 0);
        end
        if (q_dat.size() == 255) begin
            chk("t1_sop", q_sop[0], 1);
            chk("t1_eop", q_eop[254], 1);
            chk("t1_first_cyc", q_cyc[0], 2);
            chk("t1_contig", q_cyc[254] - q_cyc[0], 254);
        end
        chk("t1_busy_cycles", busy_cnt, 255);
        clear_mon();
        s_len[0] = 3; s_base[0] = 8'h10; s_reps[0] = 1;
        s_len[1] = 3; s_base[1] = 8'h20; s_reps[1] = 1;
        tick();
        tick();
        chk("t1_rrptr_grant", grant_id, 1);
        chk("t1_rrptr_data", cw_out_data, 8'h20);
        run_idle("t1b", 50);

        // 2: contention from reset, expect channels 0,1,0
        reset_dut();
        clear_mon();
        s_len[0] = 5; s_base[0] = 8'h50; s_reps[0] = 2;
        s_len[1] = 4; s_base[1] = 8'h60; s_reps[1] = 1;
        run_idle("t2", 100);
        chk("t2_beats", q_dat.size(), 14);
        if (q_dat.size() == 14) begin
            for (int k = 0; k < 14; k++) begin
                exp_c = (k >= 5 && k < 9);
                exp_d = (k < 5) ? 8'h50 + 8'(k) : (k < 9) ? 8'h60 + 8'(k - 5) : 8'h50 + 8'(k - 9);
                chk("t2_chan", q_ch[k], exp_c);
                chk("t2_data", q_dat[k], exp_d);
            end
            chk("t2_bubble1", q_cyc[5] - q_cyc[4], 2);
            chk("t2_bubble2", q_cyc[9] - q_cyc[8], 2);
        end

        // 3: toggling backpressure with the other source waiting
        reset_dut();
        clear_mon();
        s_len[0] = 20; s_base[0] = 8'h40; s_reps[0] = 1;
        s_len[1] = 10; s_base[1] = 8'h80; s_reps[1] = 1;
        tog = 1'b1; chk_rdy = 1'b1;
        run_idle("t3", 200);
        tog = 1'b0; chk_rdy = 1'b0; cw_out_ready = 1'b1;
        chk("t3_beats", q_dat.size(), 30);
        if (q_dat.size() == 30) begin
            for (int k = 0; k < 30; k++) begin
                j = (k < 20) ? k : k - 20;
                exp_d = ((k < 20) ? 8'h40 : 8'h80) + 8'(j);
                chk("t3_data", q_dat[k], exp_d);
                chk("t3_chan", q_ch[k], (k >= 20));
                chk("t3_era", q_era[k], (j % 4 == 3));
            end
        end

        // 4: orphan flush in IDLE
        reset_dut();
        clear_mon();
        s_orph[1] = 1'b1;
        tick();
        chk("t4_flush_rdy", req_ready[1], 1);
        chk("t4_other_rdy", req_ready[0], 0);
        chk("t4_no_valid", cw_out_valid, 0);
        tick();
        chk("t4_orph_set", orphan_err, 1);
        chk("t4_flush_done", req_valid[1], 0);
        repeat (5) tick();
        chk("t4_orph_hold", orphan_err, 1);
        chk("t4_no_beats", q_dat.size(), 0);

        // 5: async reset mid-codeword (rr_ptr first moved to 1)
        clear_mon();
        s_len[0] = 3; s_base[0] = 8'h30; s_reps[0] = 1;
        run_idle("t5a", 20);
        clear_mon();
        s_len[1] = 255; s_base[1] = 8'h00; s_reps[1] = 1;
        for (int k = 0; k < 200 && q_dat.size() < 100; k++) tick();
        chk("t5_reached", q_dat.size(), 100);
        chk("t5_pre_grant", grant_id, 1);
        rst = 1'b1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_valid", cw_out_valid, 0);
        chk("t5_ready", req_ready, 0);
        chk("t5_grant", grant_id, 0);
        chk("t5_orph", orphan_err, 0);
        reset_dut();
        clear_mon();
        s_len[0] = 2; s_base[0] = 8'h70; s_reps[0] = 1;
        s_len[1] = 2; s_base[1] = 8'h90; s_reps[1] = 1;
        tick();
        tick();
        chk("t5_regrant", grant_id, 0);
        chk("t5_regrant_busy", busy, 1);
        run_idle("t5b", 30);

        // 6: length check, short then full codeword
`ifdef RS_SYN_ARB_LEN_CHECK_EN
        exp_len = 1;
`else
        exp_len = 0;
`endif
        reset_dut();
        clear_mon();
        s_len[0] = 254; s_base[0] = 8'h01; s_reps[0] = 1;
        run_idle("t6a", 300);
        chk("t6_short_pulses", len_cnt, exp_len);
        if (exp_len == 1) chk("t6_pulse_align", len_cyc, eop_cyc + 1);
        clear_mon();
        s_len[0] = 255; s_base[0] = 8'h01; s_reps[0] = 1;
        run_idle("t6b", 300);
        chk("t6_full_pulses", len_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
